bus_perf_monitor: RTL



---
 rtl/perf_mon_pkg.sv | 35 +++
 rtl/perf_mon_counter.sv | 78 +++++++
 rtl/bus_perf_monitor.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/perf_mon_pkg.sv
// ---------------------------------------------------------------------------
// perf_mon_pkg
// Shared definitions for the bus performance monitor: register word offsets,
// CTRL bit positions, the CTRL field struct and a byte-lane mask helper.
// No ports; imported by bus_perf_monitor and perf_mon_counter.
// ---------------------------------------------------------------------------
package perf_mon_pkg;

    // Byte offsets of the register map (only bits [9:2] are decoded)
    localparam logic [9:0] CTRL_OFFSET    = 10'h000;
    localparam logic [9:0] STATUS_OFFSET  = 10'h004;
    localparam logic [9:0] OVF_OFFSET     = 10'h008;
    localparam logic [9:0] EN_MASK_OFFSET = 10'h00C;
    localparam logic [9:0] SHADOW_BASE    = 10'h100;

    // CTRL bit indices
    localparam int CTRL_RUN_BIT   = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int CTRL_SNAP_BIT  = 2;
    localparam int CTRL_HALT_BIT  = 3;

    // Low nibble of a CTRL write, MSB first so it can be cast from wdata[3:0]
    typedef struct packed {
        logic halt;
        logic snap;
        logic clear;
        logic run;
    } ctrl_t;

    // Expand four byte enables into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/perf_mon_counter.sv
// ---------------------------------------------------------------------------
// perf_mon_counter
// One event counter with its snapshot shadow and sticky overflow flag.
// Build option: PERF_MON_SATURATE_EN -- when defined the counter holds at
// all-ones instead of wrapping to zero (overflow flag is set either way).
//
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset
//   inc     in   increment request for this cycle
//   clear   in   force count to zero (wins over inc)
//   snap    in   copy the pre-update count into the shadow
//   ovf_clr in   clear the overflow flag (a same-cycle overflow wins)
//   shadow  out  last snapshot of the count
//   ovf     out  sticky overflow flag
// ---------------------------------------------------------------------------
module perf_mon_counter
    import perf_mon_pkg::*;
#(
    parameter int CounterWidth = 40
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    inc,
    input  logic                    clear,
    input  logic                    snap,
    input  logic                    ovf_clr,
    output logic [CounterWidth-1:0] shadow,
    output logic                    ovf
);

`ifdef PERF_MON_SATURATE_EN
    localparam bit Saturate = 1'b1;
`else
    localparam bit Saturate = 1'b0;
`endif

    localparam logic [CounterWidth-1:0] One = CounterWidth'(1);

    logic [CounterWidth-1:0] count;
    logic                    at_max;

    assign at_max = &count;

    // Clear wins over increment; the all-ones increment wraps naturally
    // unless saturation is built in, in which case the count is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !(Saturate && at_max)) begin
            count <= count + One;
        end
    end

    // A cleared increment never overflows, and a hardware overflow beats
    // a software write-1-to-clear landing in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf <= 1'b0;
        end else if (inc && at_max && !clear) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Shadow takes the value the counter held before this cycle's update
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= count;
        end
    end

endmodule

// File: rtl/bus_perf_monitor.sv
// ---------------------------------------------------------------------------
// bus_perf_monitor
// Memory-mapped performance counters on the simple-system device bus.
// Holds address decode, CTRL / EN_MASK registers, the read mux and the
// one-cycle response path; per-counter state lives in perf_mon_counter.
// Build option: PERF_MON_SATURATE_EN (saturating counters, see sub-module).
//
// Ports:
//   clk_i       in   clock
//   rst_ni      in   asynchronous active-low reset
//   req_i       in   single-cycle bus request
//   we_i        in   write enable
//   be_i        in   byte enables
//   addr_i      in   byte address, bits [9:2] decoded
//   wdata_i     in   write data
//   rvalid_o    out  response valid, one cycle after every request
//   rdata_o     out  read data, zero unless responding to a read
//   event_i     in   per-counter increment strobes
//   halt_req_o  out  sticky halt request to the simulation controller
// ---------------------------------------------------------------------------
module bus_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int NumCounters  = 8,
    parameter int CounterWidth = 40,
    parameter int AddrWidth    = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [3:0]             be_i,
    input  logic [AddrWidth-1:0]   addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    input  logic [NumCounters-1:0] event_i,
    output logic                   halt_req_o
);

    localparam logic [7:0] NumCountersByte  = 8'(NumCounters);
    localparam logic [7:0] CounterWidthByte = 8'(CounterWidth);

    logic [7:0]             word;
    logic                   wr;
    logic                   rd;
    logic                   sel_ctrl;
    logic                   sel_status;
    logic                   sel_ovf;
    logic                   sel_en;
    logic                   sel_shadow;
    logic [4:0]             shadow_idx;
    logic                   shadow_hi;
    logic [31:0]            wmask;
    ctrl_t                  wctrl;
    logic                   ctrl_wr;
    logic                   clear_cmd;
    logic                   snap_cmd;

    logic                   run;
    logic [NumCounters-1:0] en_mask;
    logic [NumCounters-1:0] inc;
    logic [NumCounters-1:0] ovf;
    logic [NumCounters-1:0] ovf_clr;
    logic [63:0]            shadow_ext [NumCounters];
    logic [31:0]            read_data;

    logic                   unused_bits;
    assign unused_bits = ^{addr_i[AddrWidth-1:10], addr_i[1:0], wdata_i};

    assign word       = addr_i[9:2];
    assign wr         = req_i & we_i;
    assign rd         = req_i & ~we_i;
    assign sel_ctrl   = (word == CTRL_OFFSET[9:2]);
    assign sel_status = (word == STATUS_OFFSET[9:2]);
    assign sel_ovf    = (word == OVF_OFFSET[9:2]);
    assign sel_en     = (word == EN_MASK_OFFSET[9:2]);
    // Shadow window is word 0x40..0x7F: two words per counter, low word first
    assign sel_shadow = (word[7:6] == SHADOW_BASE[9:8]);
    assign shadow_idx = word[5:1];
    assign shadow_hi  = word[0];

    assign wmask      = lane_mask(be_i);
    assign wctrl      = ctrl_t'(wdata_i[3:0]);
    // Every CTRL field sits in byte lane 0, so lane 0 gates the whole write
    assign ctrl_wr    = wr & sel_ctrl & be_i[0];
    assign clear_cmd  = ctrl_wr & wctrl.clear;
    assign snap_cmd   = ctrl_wr & wctrl.snap;

    assign ovf_clr    = (wr && sel_ovf) ? (wdata_i[NumCounters-1:0] & wmask[NumCounters-1:0])
                                        : '0;
    // Uses the current run bit, so a run=0 write still lets that cycle count
    assign inc        = run ? (en_mask & event_i) : '0;

    // Run bit follows CTRL writes; halt is set-only until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run        <= 1'b0;
            halt_req_o <= 1'b0;
        end else if (ctrl_wr) begin
            run <= wctrl.run;
            if (wctrl.halt) begin
                halt_req_o <= 1'b1;
            end
        end
    end

    // Enable mask, byte-lane merged
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_mask <= '1;
        end else if (wr && sel_en) begin
            en_mask <= (en_mask & ~wmask[NumCounters-1:0])
                     | (wdata_i[NumCounters-1:0] & wmask[NumCounters-1:0]);
        end
    end

    for (genvar i = 0; i < NumCounters; i++) begin : g_counter
        logic [CounterWidth-1:0] shadow_q;

        perf_mon_counter #(
            .CounterWidth(CounterWidth)
        ) u_counter (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .inc    (inc[i]),
            .clear  (clear_cmd),
            .snap   (snap_cmd),
            .ovf_clr(ovf_clr[i]),
            .shadow (shadow_q),
            .ovf    (ovf[i])
        );

        assign shadow_ext[i] = 64'(shadow_q);
    end

    // Read mux over the current (pre-update) register state
    always_comb begin
        read_data = '0;
        if (sel_ctrl) begin
            read_data[CTRL_RUN_BIT]  = run;
            read_data[CTRL_HALT_BIT] = halt_req_o;
        end else if (sel_status) begin
            read_data = {8'h00, CounterWidthByte, NumCountersByte, 6'b0, |ovf, run};
        end else if (sel_ovf) begin
            read_data[NumCounters-1:0] = ovf;
        end else if (sel_en) begin
            read_data[NumCounters-1:0] = en_mask;
        end else if (sel_shadow) begin
            for (int i = 0; i < NumCounters; i++) begin
                if (shadow_idx == 5'(i)) begin
                    read_data = shadow_hi ? shadow_ext[i][63:32] : shadow_ext[i][31:0];
                end
            end
        end
    end

    // One-cycle response; data is forced to zero except for reads
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rd ? read_data : '0;
        end
    end

endmodule
